alu_rsp_deser: RTL and testbench

ALU_RSP_DESER -- requirements
Module: alu_rsp_deser

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_pkt_rx.sv | 65 ++++++
 rtl/alu_rsp_deser.sv | 174 +++++++++++++++++
 tb/tb_alu_rsp_deser.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU response deserializer.
//   error_flags  : 6-bit error flag field carried by an error frame
//   rsp_state_t  : frame-assembly FSM states
//   PKT_BITS     : serial packet length (start, type, 8 payload, stop)
//   CRC3_POLY    : x^3+x+1 feedback taps
//   crc3_calc    : MSB-first serial CRC3 over a 37-bit frame image
package alu_pkg;

  typedef logic [5:0] error_flags;

  typedef enum logic [1:0] {IDLE, DATA, CTL_WAIT, EMIT} rsp_state_t;

  localparam int         PKT_BITS  = 11;
  localparam logic [2:0] CRC3_POLY = 3'b011;

  // Bit-serial LFSR, init 000, unrolled over the whole frame image.
  function automatic logic [2:0] crc3_calc(input logic [36:0] bits);
    logic [2:0] c;
    c = '0;
    for (int i = 36; i >= 0; i--) begin
      if (c[2] ^ bits[i]) c = {c[1:0], 1'b0} ^ CRC3_POLY;
      else                c = {c[1:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_pkt_rx.sv
// Serial packet receiver: start(0), type, payload[7:0], stop(1), MSB first.
//   clk, rst   : clock, synchronous active-high reset
//   sout       : serial line, idles high
//   pkt_valid  : good packet; high during the stop-bit cycle (stop bit = 1)
//   pkt_type   : 0 = DATA, 1 = CTL (qualified by pkt_valid)
//   pkt_data   : payload (qualified by pkt_valid)
//   stop_err   : stop bit sampled as 0 during the stop-bit cycle
module alu_pkt_rx import alu_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       sout,
  output logic       pkt_valid,
  output logic       pkt_type,
  output logic [7:0] pkt_data,
  output logic       stop_err
);

  localparam logic [3:0] LAST = 4'(PKT_BITS - 1);

  logic       active_q, active_d;
  logic [3:0] cnt_q, cnt_d;
  logic [8:0] sh_q, sh_d;     // {type, payload}
  logic       last;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    if (!active_q) begin
      // The start bit itself is count 0, so the next bit is count 1.
      if (!sout) begin
        active_d = 1'b1;
        cnt_d    = 4'd1;
      end
    end else if (cnt_q == LAST) begin
      // Drop back to idle so a start bit on the very next cycle is seen.
      active_d = 1'b0;
      cnt_d    = '0;
    end else begin
      sh_d  = {sh_q[7:0], sout};
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      sh_q     <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
    end
  end

  // Combinational in the stop cycle so the frame FSM can register its
  // terminating pulse on the same edge that samples the stop bit.
  assign last      = active_q && (cnt_q == LAST);
  assign pkt_valid = last && sout;
  assign stop_err  = last && !sout;
  assign pkt_type  = sh_q[8];
  assign pkt_data  = sh_q[7:0];

endmodule

// File: rtl/alu_rsp_deser.sv
// ALU response deserializer: assembles serial packets into result frames
// (4 DATA + 1 CTL) or single-packet error frames.
//   clk, rst            : clock, synchronous active-high reset
//   sout                : serial response line, idles high
//   rsp_valid           : 1-cycle pulse, result frame received
//   result, flags       : held until the next rsp_valid
//   crc_ok              : CRC3 check result, qualified by rsp_valid
//   err_valid           : 1-cycle pulse, error frame received
//   err_flags           : held until the next err_valid
//   parity_ok           : error-frame parity, qualified by err_valid
//   frame_err           : 1-cycle pulse, bad stop bit or bad sequence
//   busy                : frame reception in progress
// Build option: ALU_RSP_CRC_CHK_EN builds the CRC3 checker; without it
// crc_ok reads 1 on every rsp_valid.
module alu_rsp_deser import alu_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        sout,
  output logic        rsp_valid,
  output logic [31:0] result,
  output logic [3:0]  flags,
  output logic        crc_ok,
  output logic        err_valid,
  output error_flags  err_flags,
  output logic        parity_ok,
  output logic        frame_err,
  output logic        busy
);

  logic       pkt_valid, pkt_type, stop_err;
  logic [7:0] pkt_data;

  alu_pkt_rx u_rx (
    .clk       (clk),
    .rst       (rst),
    .sout      (sout),
    .pkt_valid (pkt_valid),
    .pkt_type  (pkt_type),
    .pkt_data  (pkt_data),
    .stop_err  (stop_err)
  );

  rsp_state_t  state_q, state_d;
  logic [1:0]  dcnt_q, dcnt_d;
  logic [31:0] acc_q, acc_d;       // shadow: result only updates on success
  logic [31:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;
  logic        crc_ok_q, crc_ok_d;
  error_flags  err_flags_q, err_flags_d;
  logic        parity_ok_q, parity_ok_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        err_valid_q, err_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        line_act_q, line_act_d;  // a packet is on the line
  logic        seq_err;

  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    acc_d       = acc_q;
    result_d    = result_q;
    flags_d     = flags_q;
    crc_ok_d    = crc_ok_q;
    err_flags_d = err_flags_q;
    parity_ok_d = parity_ok_q;
    rsp_valid_d = 1'b0;
    err_valid_d = 1'b0;
    frame_err_d = 1'b0;
    seq_err     = 1'b0;

    // Mirrors the receiver's idle/active tracking for the busy output.
    line_act_d = line_act_q;
    if (!line_act_q)              line_act_d = !sout;
    else if (pkt_valid || stop_err) line_act_d = 1'b0;

    if (state_q == EMIT) begin
      state_d = IDLE;
    end else if (stop_err) begin
      seq_err = 1'b1;
    end else if (pkt_valid) begin
      case (state_q)
        IDLE: begin
          if (!pkt_type) begin
            acc_d   = {acc_q[23:0], pkt_data};
            dcnt_d  = 2'd1;
            state_d = DATA;
          end else if (pkt_data[7]) begin
            err_flags_d = pkt_data[6:1];
            parity_ok_d = (pkt_data[0] == ^pkt_data[7:1]);
            err_valid_d = 1'b1;
          end else begin
            seq_err = 1'b1;
          end
        end
        DATA: begin
          if (!pkt_type) begin
            acc_d = {acc_q[23:0], pkt_data};
            if (dcnt_q == 2'd3) begin
              dcnt_d  = '0;
              state_d = CTL_WAIT;
            end else begin
              dcnt_d = dcnt_q + 2'd1;
            end
          end else begin
            seq_err = 1'b1;
          end
        end
        CTL_WAIT: begin
          if (pkt_type && !pkt_data[7]) begin
            result_d    = acc_q;
            flags_d     = pkt_data[6:3];
`ifdef ALU_RSP_CRC_CHK_EN
            crc_ok_d    = (crc3_calc({acc_q, 1'b0, pkt_data[6:3]}) == pkt_data[2:0]);
`else
            crc_ok_d    = 1'b1;
`endif
            rsp_valid_d = 1'b1;
            state_d     = EMIT;
          end else begin
            seq_err = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (seq_err) begin
      frame_err_d = 1'b1;
      state_d     = IDLE;
      dcnt_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dcnt_q      <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      crc_ok_q    <= 1'b0;
      err_flags_q <= '0;
      parity_ok_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      line_act_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      crc_ok_q    <= crc_ok_d;
      err_flags_q <= err_flags_d;
      parity_ok_q <= parity_ok_d;
      rsp_valid_q <= rsp_valid_d;
      err_valid_q <= err_valid_d;
      frame_err_q <= frame_err_d;
      line_act_q  <= line_act_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign crc_ok    = crc_ok_q;
  assign err_valid = err_valid_q;
  assign err_flags = err_flags_q;
  assign parity_ok = parity_ok_q;
  assign frame_err = frame_err_q;
  assign busy      = line_act_q || (state_q == DATA) || (state_q == CTL_WAIT);

endmodule

// File: tb/tb_alu_rsp_deser.sv
// Scoreboard bench for alu_rsp_deser: expectations are pushed when a frame
// is driven and popped when the DUT reports the frame's terminating pulse.
module tb_alu_rsp_deser;

  logic        clk = 1'b0;
  logic        rst, sout;
  logic        rsp_valid, crc_ok, err_valid, parity_ok, frame_err, busy;
  logic [31:0] result;
  logic [3:0]  flags;
  logic [5:0]  err_flags;

  alu_rsp_deser dut (
    .clk(clk), .rst(rst), .sout(sout), .rsp_valid(rsp_valid), .result(result),
    .flags(flags), .crc_ok(crc_ok), .err_valid(err_valid), .err_flags(err_flags),
    .parity_ok(parity_ok), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam int K_NONE = 0, K_RSP = 1, K_ERR = 2, K_FERR = 3;

  typedef struct {
    int          kind;
    logic [31:0] res;
    logic [3:0]  fl;
    logic        crc;
    logic [5:0]  ef;
    logic        par;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, passes = 0, overlap = 0;
  logic [31:0] m_res = '0;
  logic [3:0]  m_fl  = '0;
  logic [5:0]  m_ef  = '0;
  logic        m_par = 1'b0;

  always @(negedge clk)
    if (int'(rsp_valid) + int'(err_valid) + int'(frame_err) > 1) overlap++;

  // Reference CRC by polynomial long division of msg*x^3 by x^3+x+1.
  function automatic logic [2:0] crc_ref(input logic [36:0] msg);
    logic [39:0] r;
    r = {msg, 3'b000};
    for (int i = 39; i >= 3; i--) if (r[i]) r[i-:4] = r[i-:4] ^ 4'b1011;
    return r[2:0];
  endfunction

  function automatic logic exp_crc(input logic [31:0] c, input logic [7:0] ctl);
`ifdef ALU_RSP_CRC_CHK_EN
    return ctl[2:0] == crc_ref({c, 1'b0, ctl[6:3]});
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [7:0] good_ctl(input logic [31:0] c, input logic [3:0] fl);
    return {1'b0, fl, crc_ref({c, 1'b0, fl})};
  endfunction

  function automatic void push_rsp(input logic [31:0] c, input logic [7:0] ctl);
    m_res = c;
    m_fl  = ctl[6:3];
    sb.push_back('{K_RSP, c, ctl[6:3], exp_crc(c, ctl), m_ef, m_par});
  endfunction

  function automatic void push_err(input logic [7:0] d);
    m_ef  = d[6:1];
    m_par = ($countones(d) % 2) == 0;   // even overall parity
    sb.push_back('{K_ERR, m_res, m_fl, 1'b0, m_ef, m_par});
  endfunction

  function automatic void push_ferr();
    sb.push_back('{K_FERR, m_res, m_fl, 1'b0, m_ef, m_par});
  endfunction

  task automatic send_pkt(input logic t, input logic [7:0] d, input logic stp = 1'b1);
    logic [10:0] b;
    b = {1'b0, t, d, stp};
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      sout = b[i];
    end
  endtask

  task automatic send_data4(input logic [31:0] c);
    for (int i = 3; i >= 0; i--) send_pkt(1'b0, c[i*8 +: 8]);
  endtask

  task automatic send_frame(input logic [31:0] c, input logic [7:0] ctl);
    send_data4(c);
    send_pkt(1'b1, ctl);
  endtask

  // Return the line to idle; the cycle this lands on is the pulse cycle.
  task automatic end_idle();
    @(negedge clk);
    sout = 1'b1;
  endtask

  task automatic wait_evt(output int kind, output int lat);
    kind = K_NONE;
    lat  = 0;
    for (int n = 0; n < 24; n++) begin
      if (rsp_valid)      kind = K_RSP;
      else if (err_valid) kind = K_ERR;
      else if (frame_err) kind = K_FERR;
      if (kind != K_NONE) break;
      lat++;
      @(negedge clk);
    end
  endtask

  // Reset state, then a line held low across reset release acts as a start bit.
  task automatic test_reset();
    logic [9:0] b;
    int k, lat;
    exp_t e;
    rst = 1'b1; sout = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({rsp_valid, err_valid, frame_err, busy, crc_ok, parity_ok} !== 6'b0)
      $display("FAIL reset_bits got %b exp 000000", {rsp_valid, err_valid, frame_err, busy, crc_ok, parity_ok}); else passes++;
    checks++; if ({result, flags, err_flags} !== 42'b0)
      $display("FAIL reset_regs got %h/%h/%h exp 0", result, flags, err_flags); else passes++;
    sout = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    push_err(8'hFF);
    b = {1'b1, 8'hFF, 1'b1};
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk);
      sout = b[i];
    end
    end_idle();
    wait_evt(k, lat);
    e = sb.pop_front();
    checks++; if (k !== e.kind || lat !== 0)
      $display("FAIL low_thru_reset kind got %0d lat %0d exp %0d lat 0", k, lat, e.kind); else passes++;
    checks++; if ({err_flags, parity_ok} !== {e.ef, e.par})
      $display("FAIL low_thru_reset_err got %b/%b exp %b/%b", err_flags, parity_ok, e.ef, e.par); else passes++;
  endtask

  task automatic test_crc_frame(input logic [7:0] ctl);
    int k, lat;
    exp_t e;
    push_rsp(32'h0, ctl);
    send_frame(32'h0, ctl);
    end_idle();
    wait_evt(k, lat);
    e = sb.pop_front();
    checks++; if (k !== e.kind || lat !== 0)
      $display("FAIL crc_frame_%h kind got %0d lat %0d exp %0d lat 0", ctl, k, lat, e.kind); else passes++;
    checks++; if (result !== e.res || flags !== e.fl)
      $display("FAIL crc_frame_%h data got %h/%b exp %h/%b", ctl, result, flags, e.res, e.fl); else passes++;
    checks++; if (crc_ok !== e.crc)
      $display("FAIL crc_frame_%h crc_ok got %b exp %b", ctl, crc_ok, e.crc); else passes++;
    checks++; if (busy !== 1'b0)
      $display("FAIL crc_frame_%h busy got %b exp 0", ctl, busy); else passes++;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0)
      $display("FAIL crc_frame_%h pulse_len rsp_valid got %b exp 0", ctl, rsp_valid); else passes++;
  endtask

  task automatic test_err_frame();
    logic [7:0] tbl [2];
    int k, lat;
    exp_t e;
    tbl[0] = 8'hC9; tbl[1] = 8'hC8;
    for (int t = 0; t < 2; t++) begin
      push_err(tbl[t]);
      send_pkt(1'b1, tbl[t]);
      end_idle();
      wait_evt(k, lat);
      e = sb.pop_front();
      checks++; if (k !== e.kind || lat !== 0)
        $display("FAIL err_frame_%h kind got %0d lat %0d exp %0d lat 0", tbl[t], k, lat, e.kind); else passes++;
      checks++; if (err_flags !== e.ef || parity_ok !== e.par)
        $display("FAIL err_frame_%h got %b/%b exp %b/%b", tbl[t], err_flags, parity_ok, e.ef, e.par); else passes++;
      checks++; if (result !== e.res)
        $display("FAIL err_frame_%h result got %h exp %h", tbl[t], result, e.res); else passes++;
      @(negedge clk);
      checks++; if (err_valid !== 1'b0)
        $display("FAIL err_frame_%h pulse_len got %b exp 0", tbl[t], err_valid); else passes++;
    end
  endtask

  // Good frame, three sequence violations (held outputs must survive), good frame.
  task automatic test_seq_violation();
    int k, lat;
    exp_t e;
    for (int t = 0; t < 5; t++) begin
      case (t)
        0: begin push_rsp(32'hCAFEF00D, good_ctl(32'hCAFEF00D, 4'b1001));
                 send_frame(32'hCAFEF00D, good_ctl(32'hCAFEF00D, 4'b1001)); end
        1: begin push_ferr(); send_pkt(1'b0, 8'h12); send_pkt(1'b0, 8'h34); send_pkt(1'b1, 8'h27); end
        2: begin push_ferr(); send_data4(32'h01020304); send_pkt(1'b0, 8'h05); end
        3: begin push_ferr(); send_data4(32'h01020304); send_pkt(1'b1, 8'hA5); end
        default: begin push_rsp(32'h12345678, good_ctl(32'h12345678, 4'b1010));
                       send_frame(32'h12345678, good_ctl(32'h12345678, 4'b1010)); end
      endcase
      end_idle();
      wait_evt(k, lat);
      e = sb.pop_front();
      checks++; if (k !== e.kind || lat !== 0)
        $display("FAIL seq_%0d kind got %0d lat %0d exp %0d lat 0", t, k, lat, e.kind); else passes++;
      checks++; if (result !== e.res || flags !== e.fl)
        $display("FAIL seq_%0d held got %h/%b exp %h/%b", t, result, flags, e.res, e.fl); else passes++;
      if (e.kind == K_RSP) begin
        checks++; if (crc_ok !== e.crc)
          $display("FAIL seq_%0d crc_ok got %b exp %b", t, crc_ok, e.crc); else passes++;
      end
    end
  endtask

  task automatic test_stop_err();
    int k, lat;
    exp_t e;
    push_ferr();
    send_pkt(1'b0, 8'h5A, 1'b0);
    end_idle();
    wait_evt(k, lat);
    e = sb.pop_front();
    checks++; if (k !== e.kind || lat !== 0)
      $display("FAIL stop_err kind got %0d lat %0d exp %0d lat 0", k, lat, e.kind); else passes++;
    checks++; if (busy !== 1'b0)
      $display("FAIL stop_err busy got %b exp 0", busy); else passes++;
  endtask

  task automatic test_reset_mid();
    int k, lat, ferr_seen;
    exp_t e;
    send_pkt(1'b0, 8'hAB);
    send_pkt(1'b0, 8'hCD);
    end_idle();
    checks++; if (busy !== 1'b1)
      $display("FAIL reset_mid busy_before got %b exp 1", busy); else passes++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_res = '0; m_fl = '0; m_ef = '0; m_par = 1'b0;
    ferr_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (frame_err) ferr_seen++;
      @(negedge clk);
    end
    checks++; if (ferr_seen !== 0)
      $display("FAIL reset_mid frame_err got %0d cycles exp 0", ferr_seen); else passes++;
    checks++; if ({busy, result, err_flags} !== 39'b0)
      $display("FAIL reset_mid cleared got %b/%h/%b exp 0", busy, result, err_flags); else passes++;
    push_rsp(32'h89ABCDEF, good_ctl(32'h89ABCDEF, 4'b0110));
    send_frame(32'h89ABCDEF, good_ctl(32'h89ABCDEF, 4'b0110));
    end_idle();
    wait_evt(k, lat);
    e = sb.pop_front();
    checks++; if (k !== e.kind || lat !== 0)
      $display("FAIL reset_mid_frame kind got %0d lat %0d exp %0d lat 0", k, lat, e.kind); else passes++;
    checks++; if (result !== e.res || flags !== e.fl || crc_ok !== e.crc)
      $display("FAIL reset_mid_frame got %h/%b/%b exp %h/%b/%b", result, flags, crc_ok, e.res, e.fl, e.crc); else passes++;
  endtask

  // Frames with the next start bit on the cycle right after the final stop bit.
  task automatic test_back_to_back();
    logic [31:0] cs [3];
    logic [7:0]  ct [3];
    int k, lat;
    exp_t e;
    for (int f = 0; f < 3; f++) begin
      cs[f] = $urandom;
      ct[f] = good_ctl(cs[f], 4'($urandom_range(0, 15)));
      push_rsp(cs[f], ct[f]);
    end
    send_frame(cs[0], ct[0]);
    for (int f = 0; f < 3; f++) begin
      fork
        begin
          if (f < 2) send_frame(cs[f+1], ct[f+1]);
          else       end_idle();
        end
        begin
          @(negedge clk);
          wait_evt(k, lat);
          e = sb.pop_front();
          checks++; if (k !== e.kind || lat !== 0)
            $display("FAIL b2b_%0d kind got %0d lat %0d exp %0d lat 0", f, k, lat, e.kind); else passes++;
          checks++; if (result !== e.res || flags !== e.fl || crc_ok !== e.crc)
            $display("FAIL b2b_%0d got %h/%b/%b exp %h/%b/%b", f, result, flags, crc_ok, e.res, e.fl, e.crc); else passes++;
        end
      join
    end
  endtask

  initial begin
    test_reset();
    test_crc_frame(8'h27);
    test_crc_frame(8'h26);
    test_err_frame();
    test_seq_violation();
    test_stop_err();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++; if (overlap !== 0)
      $display("FAIL pulse_exclusive got %0d overlapping cycles exp 0", overlap); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
